data_sram_axi_responder: RTL and testbench

- Responder for the core's data-side SRAM-like port: accepts one load/store request at a time from the memory stage and runs it as a single-beat AXI4 transaction.
- Returns load data and drives the core's data stall until the access completes.
- Holds the completed result until the whole pipeline advances, so a request held by another stall source is never re-issued.
- Sits between the core's memory stage and the AXI crossbar, beside the instruction-side bridge.

---
 rtl/data_sram_axi_responder.sv | 179 +++++++++++++++++
 tb/tb_data_sram_axi_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_axi_responder.sv
// Data-side SRAM-like port to single-beat AXI4 responder: one load/store at a time,
// result held in DONE until the whole pipeline advances.
module data_sram_axi_responder #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // core memory stage
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        data_stall,
  input  logic        longest_stall,
  // read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // write address channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StWrReq,
    StWrB,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic [2:0]  wsize;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        req_latch;
  logic        aw_fire, w_fire, r_fire;

  // Responses are accepted whatever their status; an error completes like OKAY.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp};

  // Transfer size implied by the byte-enable pattern.
  always_comb begin
    wsize = 3'd2;
    case (mem_wen)
      4'b1111:                            wsize = 3'd2;
      4'b0011, 4'b1100:                   wsize = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wsize = 3'd0;
      default:                            wsize = 3'd2;
    endcase
  end

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign r_fire  = rready & rvalid;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_latch = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_en) begin
          req_latch = 1'b1;
          state_d   = (mem_wen == 4'b0000) ? StRdAr : StWrReq;
        end
      end
      StRdAr: begin
        if (arready) state_d = StRdR;
      end
      StRdR: begin
        if (rvalid) state_d = StDone;
      end
      StWrReq: begin
        // AW and W complete independently, possibly in the same cycle.
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          state_d   = StWrB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWrB: begin
        if (bvalid) state_d = StDone;
      end
      StDone: begin
        // Wait for the whole pipeline to move so the held request is not re-issued.
        if (!longest_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      size_q    <= 3'd0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (req_latch) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wen;
        size_q  <= (mem_wen == 4'b0000) ? 3'd2 : wsize;
      end
      if (r_fire) rdata_q <= rdata;
    end
  end

  assign data_stall = ((state_q == StIdle) & mem_en) |
                      ((state_q != StIdle) & (state_q != StDone));
  assign mem_rdata  = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arvalid = (state_q == StRdAr);
  assign rready  = (state_q == StRdR);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awvalid = (state_q == StWrReq) & ~aw_done_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == StWrReq) & ~w_done_q;

  assign bready  = (state_q == StWrB);

endmodule

// File: tb/tb_data_sram_axi_responder.sv
// Scoreboard bench for data_sram_axi_responder: directed requests push expected AXI beats and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_data_sram_axi_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_en, longest_stall, extra_stall;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        data_stall;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  assign longest_stall = data_stall | extra_stall;

  data_sram_axi_responder #(.AXI_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .data_stall(data_stall), .longest_stall(longest_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {logic [31:0] addr; logic [2:0] size;} addr_t;
  typedef struct {logic [31:0] data; logic [3:0] strb;} wbeat_t;
  typedef struct {logic is_load; logic [31:0] rdata; int stall;} cpl_t;

  addr_t  exp_ar[$];
  addr_t  exp_aw[$];
  wbeat_t exp_w[$];
  cpl_t   exp_cpl[$];

  int tests = 0;
  int fails = 0;

  // Slave knobs: cycles of valid seen before ready (or of ready seen before valid on R/B).
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [31:0] r_data_k = 32'h0;
  logic [1:0]  r_resp_k = 2'b00;
  logic [1:0]  b_resp_k = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI slave model
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; bresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      rdata = r_data_k;
      rresp = r_resp_k;
      bresp = b_resp_k;
      if (arvalid) begin arready = (ar_c >= ar_lat); ar_c++; end
      else begin arready = 1'b0; ar_c = 0; end
      if (rready) begin rvalid = (r_c >= r_lat); r_c++; end
      else begin rvalid = 1'b0; r_c = 0; end
      if (awvalid) begin awready = (aw_c >= aw_lat); aw_c++; end
      else begin awready = 1'b0; aw_c = 0; end
      if (wvalid) begin wready = (w_c >= w_lat); w_c++; end
      else begin wready = 1'b0; w_c = 0; end
      if (bready) begin bvalid = (b_c >= b_lat); b_c++; end
      else begin bvalid = 1'b0; b_c = 0; end
    end
  end

  // Monitor / scoreboard
  initial begin
    int          stall_cnt;
    logic        cpl_active, ar_wait, aw_wait, w_wait;
    logic [31:0] ar_addr_p, aw_addr_p, w_data_p;
    addr_t       a;
    wbeat_t      w;
    stall_cnt = 0; cpl_active = 1'b0;
    ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
    ar_addr_p = 32'h0; aw_addr_p = 32'h0; w_data_p = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_cnt = 0; cpl_active = 1'b0; exp_cpl.delete();
        ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
      end else begin
        // a valid not yet accepted must stay up with stable payload
        if (ar_wait) begin
          check("ar_valid_held", {31'h0, arvalid}, 32'd1);
          check("ar_addr_stable", araddr, ar_addr_p);
        end
        if (aw_wait) begin
          check("aw_valid_held", {31'h0, awvalid}, 32'd1);
          check("aw_addr_stable", awaddr, aw_addr_p);
        end
        if (w_wait) begin
          check("w_valid_held", {31'h0, wvalid}, 32'd1);
          check("w_data_stable", wdata, w_data_p);
        end
        if (arvalid && arready) begin
          check("ar_expected", {31'h0, exp_ar.size() > 0}, 32'd1);
          if (exp_ar.size() > 0) begin
            a = exp_ar.pop_front();
            check("araddr", araddr, a.addr);
            check("arsize", {29'h0, arsize}, {29'h0, a.size});
            check("arid", {28'h0, arid}, 32'd1);
            check("arlen_arburst", {22'h0, arlen, arburst}, {22'h0, 8'd0, 2'b01});
          end
        end
        if (awvalid && awready) begin
          check("aw_expected", {31'h0, exp_aw.size() > 0}, 32'd1);
          if (exp_aw.size() > 0) begin
            a = exp_aw.pop_front();
            check("awaddr", awaddr, a.addr);
            check("awsize", {29'h0, awsize}, {29'h0, a.size});
            check("awid", {28'h0, awid}, 32'd1);
            check("awlen_awburst", {22'h0, awlen, awburst}, {22'h0, 8'd0, 2'b01});
          end
        end
        if (wvalid && wready) begin
          check("w_expected", {31'h0, exp_w.size() > 0}, 32'd1);
          if (exp_w.size() > 0) begin
            w = exp_w.pop_front();
            check("wdata", wdata, w.data);
            check("wstrb_wlast", {27'h0, wstrb, wlast}, {27'h0, w.strb, 1'b1});
          end
        end
        ar_wait = arvalid && !arready; ar_addr_p = araddr;
        aw_wait = awvalid && !awready; aw_addr_p = awaddr;
        w_wait  = wvalid && !wready;   w_data_p  = wdata;
        if (data_stall) begin
          stall_cnt++;
        end else if (mem_en) begin
          check("cpl_expected", {31'h0, exp_cpl.size() > 0}, 32'd1);
          if (exp_cpl.size() > 0) begin
            if (!cpl_active) begin
              check("stall_cycles", stall_cnt, exp_cpl[0].stall);
              cpl_active = 1'b1;
            end
            if (exp_cpl[0].is_load) check("mem_rdata", mem_rdata, exp_cpl[0].rdata);
            if (!longest_stall) begin
              void'(exp_cpl.pop_front());
              cpl_active = 1'b0;
              stall_cnt  = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_stall && n < 200);
    check("req_done_in_time", {31'h0, data_stall}, 32'd0);
  endtask

  task automatic do_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [2:0] size, input int stall,
                        input int hold);
    addr_t  a;
    wbeat_t w;
    cpl_t   c;
    a.addr = addr;
    if (wen == 4'b0000) begin
      a.size = 3'd2;
      exp_ar.push_back(a);
    end else begin
      a.size = size;
      exp_aw.push_back(a);
      w.data = wd;
      w.strb = wen;
      exp_w.push_back(w);
    end
    c.is_load = (wen == 4'b0000);
    c.rdata   = rd;
    c.stall   = stall;
    exp_cpl.push_back(c);
    @(posedge clk);
    #1;
    r_data_k    = rd;
    mem_en      = 1'b1;
    mem_wen     = wen;
    mem_addr    = addr;
    mem_wdata   = wd;
    extra_stall = (hold > 0);
    wait_done();
    if (hold > 1) repeat (hold - 1) @(negedge clk);
    if (hold > 0) begin
      @(posedge clk);
      #1;
      extra_stall = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mem_en  = 1'b0;
    mem_wen = 4'b0000;
  endtask

  initial begin
    addr_t a;
    cpl_t  c;
    int    n;
    mem_en = 1'b0; mem_wen = 4'b0000; mem_addr = 32'h0; mem_wdata = 32'h0; extra_stall = 1'b0;

    #2;
    check("rst_arvalid", {31'h0, arvalid}, 32'd0);
    check("rst_awvalid", {31'h0, awvalid}, 32'd0);
    check("rst_wvalid", {31'h0, wvalid}, 32'd0);
    check("rst_rready_bready", {30'h0, rready, bready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_data_stall", {31'h0, data_stall}, 32'd0);
    #20;
    resetn = 1'b1;

    // basic load, zero-wait slave
    do_req(4'b0000, 32'h1FC0_0010, 32'h0, 32'hDEAD_BEEF, 3'd2, 3, 0);
    // halfword store: AW accepted at once, W on the third cycle
    w_lat = 2;
    do_req(4'b1100, 32'h8000_0002, 32'h1234_0000, 32'h0, 3'd1, 5, 0);
    w_lat = 0;
    // byte store, AW and W together
    do_req(4'b0010, 32'h8000_0011, 32'h0000_AB00, 32'h0, 3'd0, 3, 0);
    do_req(4'b1111, 32'h8000_0020, 32'h0102_0304, 32'h0, 3'd2, 3, 0);
    do_req(4'b0110, 32'h8000_0024, 32'h00BE_EF00, 32'h0, 3'd2, 3, 0);
    do_req(4'b0011, 32'h8000_0028, 32'h0000_5678, 32'h0, 3'd1, 3, 0);
    b_resp_k = 2'b10;
    do_req(4'b1000, 32'h8000_002B, 32'h9900_0000, 32'h0, 3'd0, 3, 0);
    b_resp_k = 2'b00;
    // load held in DONE by another stall source for 5 cycles
    do_req(4'b0000, 32'h1FC0_0020, 32'h0, 32'hCAFE_F00D, 3'd2, 3, 5);
    // error response and slow slave
    r_resp_k = 2'b10; ar_lat = 2; r_lat = 1;
    do_req(4'b0000, 32'h1FC0_0024, 32'h0, 32'h0BAD_C0DE, 3'd2, 6, 0);
    r_resp_k = 2'b00; ar_lat = 0; r_lat = 0;
    // W before AW
    aw_lat = 2;
    do_req(4'b1111, 32'h8000_0030, 32'hA5A5_5A5A, 32'h0, 3'd2, 5, 0);
    aw_lat = 0;

    // reset while R is outstanding
    r_lat = 3;
    a.addr = 32'h1FC0_0040; a.size = 3'd2;
    exp_ar.push_back(a);
    c.is_load = 1'b1; c.rdata = 32'h7777_0000; c.stall = 0;
    exp_cpl.push_back(c);
    @(posedge clk);
    #1;
    r_data_k = 32'h7777_0000;
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h1FC0_0040;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rready && n < 50);
    check("reach_rd_r", {31'h0, rready}, 32'd1);
    #2;
    resetn = 1'b0;
    mem_en = 1'b0;
    #1;
    check("midrst_arvalid_rready", {30'h0, arvalid, rready}, 32'd0);
    check("midrst_mem_rdata", mem_rdata, 32'h0);
    check("midrst_data_stall", {31'h0, data_stall}, 32'd0);
    @(negedge clk);
    #2;
    resetn = 1'b1;
    r_lat = 0;
    do_req(4'b0000, 32'h1FC0_0050, 32'h0, 32'h5A5A_5A5A, 3'd2, 3, 0);

    repeat (4) @(negedge clk);
    check("ar_queue_empty", exp_ar.size(), 32'd0);
    check("aw_queue_empty", exp_aw.size(), 32'd0);
    check("w_queue_empty", exp_w.size(), 32'd0);
    check("cpl_queue_empty", exp_cpl.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
